// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB request master.
// The state encoding is fixed so that debug views and waveforms stay stable.
// Default widths match a 32-bit address, byte-wide peripheral bus.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_req_master.sv
// Purpose: turns single cmd_valid/cmd_ready requests into APB transfers; optional wait-state timeout under APB_TIMEOUT_EN.
// Latency: accept edge -> SETUP -> ACCESS -> response pulse; 3 cycles per transfer with zero wait states.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid seen while a transfer is in flight is dropped, not queued.
import apb_pkg::*;

module apb_req_master #(
  parameter int ADDR_W    = APB_ADDR_W,
  parameter int DATA_W    = APB_DATA_W,
  parameter int TO_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        r_state;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  apb_state_t        w_state_nxt;
  logic              w_accept;
  logic              w_cmd_ready_nxt;
  logic              w_psel_nxt;
  logic              w_penable_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_err_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;

`ifdef APB_TIMEOUT_EN
  // Counter only needs to reach TO_CYCLES-1; the abort fires on the cycle it would hit TO_CYCLES.
  localparam int TO_CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic [TO_CNT_W-1:0] w_to_cnt_nxt;
`endif

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_cmd_ready_nxt = 1'b0;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
`ifdef APB_TIMEOUT_EN
    w_to_cnt_nxt    = r_to_cnt;
`endif
    case (r_state)
      IDLE: begin
        w_accept = cmd_valid && r_cmd_ready;
        if (w_accept) begin
          w_state_nxt = SETUP;
          w_psel_nxt  = 1'b1;
`ifdef APB_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
        end else begin
          w_cmd_ready_nxt = 1'b1;
        end
      end
      SETUP: begin
        w_state_nxt   = ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end
      ACCESS: begin
        // pready is checked first so a completion on the limit cycle still wins over the timeout.
        if (pready) begin
          w_state_nxt     = IDLE;
          w_cmd_ready_nxt = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = pslverr;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
        end else if (r_to_cnt == TO_CNT_W'(TO_CYCLES - 1)) begin
          w_state_nxt     = IDLE;
          w_cmd_ready_nxt = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
`endif
        end else begin
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
          w_to_cnt_nxt  = r_to_cnt + TO_CNT_W'(1);
`endif
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_cmd_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; reset clears the bus immediately and drops any in-flight transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      // Address/direction/data are loaded only on accept, so they hold through the transfer and in IDLE.
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  // Wait-state counter for the timeout abort.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
    end
  end
`endif

  assign cmd_ready = r_cmd_ready;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: memory slave with per-transfer wait states, queue scoreboard, decoupled monitor.
// Build with APB_TIMEOUT_EN defined to also exercise the wait-state timeout (TO_CYCLES=4).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_apb_req_master;

  localparam int AW    = 32;
  localparam int DW    = 8;
  localparam int TO    = 4;
  localparam int MEM_N = 16;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_req_master #(.ADDR_W(AW), .DATA_W(DW), .TO_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          exp_q[$];
  int            wait_q[$];
  logic [DW-1:0] ref_mem[MEM_N];
  logic [DW-1:0] slv_mem[MEM_N];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            rdy_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // APB memory slave: addresses >= MEM_N raise pslverr; random noise on its outputs outside ACCESS.
  initial begin : slave
    bit slv_busy = 1'b0;
    int slv_wait = 0;
    for (int i = 0; i < MEM_N; i++) slv_mem[i] = '0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        slv_busy = 1'b0;
        pready   = 1'b0;
      end else if (psel && penable) begin
        if (!slv_busy) begin
          slv_busy = 1'b1;
          slv_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
        if (slv_wait > 0) begin
          slv_wait--;
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = DW'($urandom);
        end else begin
          pready   = 1'b1;
          pslverr  = (paddr >= AW'(MEM_N));
          prdata   = (!pwrite && !pslverr) ? slv_mem[paddr[3:0]] : '0;
          if (pwrite && !pslverr) slv_mem[paddr[3:0]] = pwdata;
          slv_busy = 1'b0;
        end
      end else begin
        slv_busy = 1'b0;
        pready   = 1'($urandom);
        pslverr  = 1'($urandom);
        prdata   = DW'($urandom);
      end
    end
  end

  // Monitor: tracks bus activity per transfer and scores each response against the queue head.
  initial begin : monitor
    int   psel_cnt = 0;
    int   acc_cnt  = 0;
    bit   tr_bad   = 1'b0;
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        psel_cnt = 0; acc_cnt = 0; tr_bad = 1'b0;
      end else begin
        if (psel) begin
          psel_cnt++;
          if (exp_q.size() == 0) tr_bad = 1'b1;
          else if (paddr !== exp_q[0].addr || pwrite !== exp_q[0].wr ||
                   (exp_q[0].wr && pwdata !== exp_q[0].wdata)) tr_bad = 1'b1;
        end
        if (penable) begin
          acc_cnt++;
          if (!psel) tr_bad = 1'b1;
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("access_cycles", 64'(acc_cnt), 64'(e.acc));
            check("psel_cycles", 64'(psel_cnt), 64'(e.acc + 1));
            check("bus_stable", 64'(tr_bad), 64'd0);
            check("psel_at_rsp", 64'({psel, penable}), 64'd0);
            check("paddr_hold", 64'(paddr), 64'(e.addr));
          end
          psel_cnt = 0; acc_cnt = 0; tr_bad = 1'b0;
        end
        if (rdy_chk) check("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() == 0));
      end
    end
  end

  function automatic bit timed_out(input int waits);
`ifdef APB_TIMEOUT_EN
    return waits >= TO;
`else
    return 1'b0;
`endif
  endfunction

  // Drive a command until accepted; the expected response is queued on the accepting edge.
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data, input int waits);
    exp_t e;
    int   n = 0;
    bit   to   = timed_out(waits);
    bit   aerr = (addr >= AW'(MEM_N));
    e.wr = wr; e.addr = addr; e.wdata = data;
    e.acc   = to ? TO : waits + 1;
    e.err   = to || aerr;
    e.rdata = (wr || e.err) ? '0 : ref_mem[addr[3:0]];
    if (wr && !e.err) ref_mem[addr[3:0]] = data;
    wait_q.push_back(waits);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    exp_q.push_back(e);
    @(negedge pclk);
  endtask

  // Spray junk commands while busy (must be ignored), stop on the idle cycle.
  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      @(negedge pclk);
      n++;
    end
    cmd_valid = 1'b0;
    if (!cmd_ready) check("idle_timeout", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data, input int waits);
    issue_cmd(wr, addr, data, waits);
    wait_idle();
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = '0;

    // Reset values.
    repeat (2) @(negedge pclk);
    check("rst_bus", 64'({psel, penable, pwrite}), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    presetn = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);
    rdy_chk = 1'b1;

    // Directed: write/read addr 3, out-of-range write, 5 wait states.
    do_cmd(1'b1, 32'd3, 8'hA5, 0);
    do_cmd(1'b0, 32'd3, 8'h00, 0);
    do_cmd(1'b1, 32'd20, 8'h5A, 0);
    do_cmd(1'b0, 32'd7, 8'h00, 5);

    // Random traffic, mostly back-to-back.
    for (int k = 0; k < 60; k++) begin
      do_cmd(1'($urandom), AW'($urandom_range(0, 19)), DW'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge pclk);
    end

    // Reset while in ACCESS: bus clears at once, no response, ready one edge after release.
    issue_cmd(1'b0, 32'd5, 8'h00, 10);
    n = 0;
    while (!penable && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("reached_access", 64'(penable), 64'd1);
    rdy_chk = 1'b0;
    presetn = 1'b0;
    #1;
    check("rst_mid_bus", 64'({psel, penable}), 64'd0);
    check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    check("rst_mid_ready", 64'(cmd_ready), 64'd0);
    exp_q.delete();
    wait_q.delete();
    repeat (2) begin
      @(negedge pclk);
      check("rst_hold_rsp", 64'(rsp_valid), 64'd0);
    end
    presetn = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("ready_after_abort", 64'(cmd_ready), 64'd1);
    check("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
    rdy_chk = 1'b1;
    do_cmd(1'b0, 32'd3, 8'h00, 1);

`ifdef APB_TIMEOUT_EN
    // Slave never ready -> timeout; completion on the limit cycle wins; data intact afterwards.
    do_cmd(1'b0, 32'd2, 8'h00, 50);
    do_cmd(1'b1, 32'd4, 8'h3C, TO - 1);
    do_cmd(1'b0, 32'd4, 8'h00, 0);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter TO_CYCLES, default 16, wait-state limit (used only with APB_TIMEOUT_EN).
REQ-004 SHALL have port pclk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port presetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  in  ADDR_W  command address.
REQ-010 SHALL have port cmd_wdata  in  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  out  DATA_W  read data, 0 for writes.
REQ-013 SHALL have port rsp_err  out  1  slave error or timeout.
REQ-014 SHALL have port paddr  out  ADDR_W  APB address.
REQ-015 SHALL have port psel  out  1  APB select.
REQ-016 SHALL have port penable  out  1  APB enable.
REQ-017 SHALL have port pwrite  out  1  APB direction.
REQ-018 SHALL have port pwdata  out  DATA_W  APB write data.
REQ-019 SHALL have port prdata  in  DATA_W  APB read data.
REQ-020 SHALL have port pready  in  1  APB ready.
REQ-021 SHALL have port pslverr  in  1  APB slave error.

Function
REQ-022 SHALL implement FSM IDLE, SETUP, ACCESS; all outputs registered.
REQ-023 SHALL drive cmd_ready=1 only in IDLE; accept on cmd_valid&&cmd_ready, latch write/addr/wdata, go to SETUP.
REQ-024 SETUP SHALL drive psel=1, penable=0, paddr/pwrite/pwdata from latched values, then go unconditionally to ACCESS.
REQ-025 ACCESS SHALL drive psel=1, penable=1; hold while pready=0 (unbounded wait states without timeout).
REQ-026 On pready=1 in ACCESS: next cycle rsp_valid=1, rsp_err=pslverr, rsp_rdata=prdata (read) or 0 (write), psel=penable=0, state IDLE.
REQ-027 Zero-wait transfer: accept at edge E0, SETUP E0-E1, ACCESS E1-E2, rsp_valid and cmd_ready high E2-E3; back-to-back throughput one transfer per 3 cycles.
REQ-028 paddr/pwrite/pwdata SHALL stay stable SETUP through completion and hold last value in IDLE.
REQ-029 pready/pslverr/prdata SHALL be ignored outside ACCESS.
REQ-030 cmd_valid while not in IDLE SHALL be ignored (not accepted, not queued).

Reset
REQ-031 presetn low SHALL force IDLE immediately, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=0, rsp_rdata=0, cmd_ready=0 during reset.
REQ-032 Reset mid-transfer SHALL abort without a rsp_valid pulse; cmd_ready=1 on first edge after release.

Configuration
REQ-033 With APB_TIMEOUT_EN defined, SHALL count ACCESS cycles with pready=0; at TO_CYCLES abort: psel=penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, go IDLE.
REQ-034 If pready=1 in the same cycle the count reaches TO_CYCLES, normal completion SHALL win; counter clears on entry to SETUP.
REQ-035 Without APB_TIMEOUT_EN, no counter SHALL exist; TO_CYCLES unused.

Structure
REQ-036 Package apb_pkg SHALL hold the state enum typedef (IDLE=0, SETUP=1, ACCESS=2) and default ADDR_W/DATA_W constants.
REQ-037 SHALL be a single module, no sub-modules.

Verification
REQ-038 Write addr 3 data 0xA5 to the APB memory slave -> psel high 2 cycles, penable high 1 cycle, rsp_valid pulse with rsp_err=0.
REQ-039 Read addr 3 after REQ-038 -> rsp_rdata=0xA5, rsp_err=0, pwrite=0 during SETUP/ACCESS.
REQ-040 Write addr 20 -> pslverr sampled, rsp_err=1, rsp_rdata=0.
REQ-041 Slave holds pready=0 for 5 cycles -> ACCESS lasts 6 cycles, paddr stable, single rsp_valid; with APB_TIMEOUT_EN and TO_CYCLES=4, pready never high -> rsp_err=1 after 4 wait cycles.
REQ-042 presetn low during ACCESS -> psel/penable 0 same cycle, no rsp_valid, cmd_ready=1 one edge after release.
